// File: rtl/score_table.sv
// Per-user score table for the memory-tester game: 8 users x 8-bit scores.
// Loss penalty is enabled by defining SCORE_LOSS_PENALTY_EN; the default build ignores losses.
module score_table (
  input  logic       clock,
  input  logic       rst,
  input  logic       log_out,
  input  logic       green_user,
  input  logic [2:0] internal_id,
  input  logic       auth_bit,
  input  logic       win,
  input  logic       loose,
  input  logic       disp_button,
  input  logic [3:0] level_num,
  output logic [7:0] disp_out,
  output logic       green_max
);

  localparam int NUM_USERS = 8;
  localparam int SCORE_W   = 8;

  logic [NUM_USERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic                              active_q, active_d;
  logic [2:0]                        active_id_q, active_id_d;
  logic                              win_q, loose_q;
  logic [SCORE_W-1:0]                disp_out_q, disp_out_d;
  logic                              green_max_q, green_max_d;

  logic               win_edge, loose_edge;
  logic [SCORE_W-1:0] own_score, maxval, add_val;
  logic [SCORE_W:0]   add_wide;
  logic [NUM_USERS-1:0] beats;

  assign win_edge   = win & ~win_q;
  assign loose_edge = loose & ~loose_q;
  assign own_score  = score_q[active_id_q];

  assign add_wide = {1'b0, own_score} + {5'b0, level_num};
  assign add_val  = add_wide[SCORE_W] ? {SCORE_W{1'b1}} : add_wide[SCORE_W-1:0];

`ifdef SCORE_LOSS_PENALTY_EN
  logic [SCORE_W-1:0] sub_val;
  assign sub_val = (own_score < {4'b0, level_num}) ? '0 : own_score - {4'b0, level_num};
`endif

  // The logged-in entry must strictly beat every other entry; a tie does not count.
  for (genvar j = 0; j < NUM_USERS; j++) begin : g_beats
    assign beats[j] = (active_id_q == 3'(j)) || (own_score > score_q[j]);
  end

  always_comb begin
    maxval = '0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (score_q[i] > maxval) maxval = score_q[i];
    end
  end

  always_comb begin
    active_d    = active_q;
    active_id_d = active_id_q;
    score_d     = score_q;
    if (log_out) begin
      active_d = 1'b0;
    end else if (!active_q) begin
      if (green_user && auth_bit) begin
        active_d    = 1'b1;
        active_id_d = internal_id;
      end
    end else begin
      if (win_edge && !loose_edge) begin
        score_d[active_id_q] = add_val;
      end
`ifdef SCORE_LOSS_PENALTY_EN
      else if (loose_edge && !win_edge) begin
        score_d[active_id_q] = sub_val;
      end
`endif
    end
  end

  // Outputs are a pipeline stage behind the table state.
  always_comb begin
    disp_out_d  = '0;
    green_max_d = 1'b0;
    if (active_q) begin
      disp_out_d  = disp_button ? own_score : maxval;
      green_max_d = &beats;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      score_q     <= '0;
      active_q    <= 1'b0;
      active_id_q <= '0;
      win_q       <= 1'b0;
      loose_q     <= 1'b0;
      disp_out_q  <= '0;
      green_max_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      active_q    <= active_d;
      active_id_q <= active_id_d;
      win_q       <= win;
      loose_q     <= loose;
      disp_out_q  <= disp_out_d;
      green_max_q <= green_max_d;
    end
  end

  assign disp_out  = disp_out_q;
  assign green_max = green_max_q;

endmodule

// File: tb/tb_score_table.sv
// Directed bench for score_table; expectations follow the SCORE_LOSS_PENALTY_EN build setting.
module tb_score_table;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       log_out = 1'b0;
  logic       green_user = 1'b0;
  logic [2:0] internal_id = '0;
  logic       auth_bit = 1'b0;
  logic       win = 1'b0;
  logic       loose = 1'b0;
  logic       disp_button = 1'b0;
  logic [3:0] level_num = '0;
  logic [7:0] disp_out;
  logic       green_max;

  int vectors = 0;
  int errors  = 0;

`ifdef SCORE_LOSS_PENALTY_EN
  localparam logic [7:0] S5 = 8'd15;
  localparam logic       GM6_AT16 = 1'b1;
`else
  localparam logic [7:0] S5 = 8'd16;
  localparam logic       GM6_AT16 = 1'b0;
`endif

  score_table dut (
    .clock(clock), .rst(rst), .log_out(log_out), .green_user(green_user),
    .internal_id(internal_id), .auth_bit(auth_bit), .win(win), .loose(loose),
    .disp_button(disp_button), .level_num(level_num),
    .disp_out(disp_out), .green_max(green_max)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic login(input logic [2:0] id);
    green_user = 1'b1; auth_bit = 1'b1; internal_id = id;
    tick();
    green_user = 1'b0; auth_bit = 1'b0;
    tick();
  endtask

  task automatic logout();
    log_out = 1'b1;
    tick();
    log_out = 1'b0;
    tick();
  endtask

  task automatic win_pulse(input logic [3:0] lvl);
    level_num = lvl; win = 1'b1;
    tick();
    win = 1'b0;
    tick();
  endtask

  task automatic loose_pulse(input logic [3:0] lvl);
    level_num = lvl; loose = 1'b1;
    tick();
    loose = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++;
    if (disp_out !== 8'd0 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL reset: disp_out=%0d green_max=%0b expected 0/0", disp_out, green_max);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_v [5] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd15};
    disp_button = 1'b1;
    login(3'd5);
    vectors++;
    if (disp_out !== 8'd0 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL login_id5: disp_out=%0d green_max=%0b expected 0/0", disp_out, green_max);
    end
    for (int i = 0; i < 5; i++) begin
      win_pulse(4'(i + 1));
      vectors++;
      if (disp_out !== exp_v[i] || green_max !== 1'b1) begin
        errors++;
        $display("FAIL accumulate[%0d]: disp_out=%0d green_max=%0b expected %0d/1",
                 i, disp_out, green_max, exp_v[i]);
      end
    end
  endtask

  task automatic test_penalty();
    loose_pulse(4'd1);
    vectors++;
    if (disp_out !== S5 - 8'd1) begin
      errors++;
      $display("FAIL penalty_loss: disp_out=%0d expected %0d", disp_out, S5 - 8'd1);
    end
    win_pulse(4'd1);
    vectors++;
    if (disp_out !== S5) begin
      errors++;
      $display("FAIL penalty_win: disp_out=%0d expected %0d", disp_out, S5);
    end
  endtask

  task automatic test_logout_highscore();
    logout();
    vectors++;
    if (disp_out !== 8'd0 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL logout: disp_out=%0d green_max=%0b expected 0/0", disp_out, green_max);
    end
    login(3'd6);
    for (int i = 1; i <= 5; i++) win_pulse(4'(i));
    vectors++;
    if (disp_out !== 8'd15 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL tie_id6: disp_out=%0d green_max=%0b expected 15/0", disp_out, green_max);
    end
    win_pulse(4'd1);
    vectors++;
    if (disp_out !== 8'd16 || green_max !== GM6_AT16) begin
      errors++;
      $display("FAIL lead_id6: disp_out=%0d green_max=%0b expected 16/%0b", disp_out, green_max, GM6_AT16);
    end
    disp_button = 1'b0;
    tick();
    vectors++;
    if (disp_out !== 8'd16) begin
      errors++;
      $display("FAIL maxval: disp_out=%0d expected 16", disp_out);
    end
    disp_button = 1'b1;
    // a new presenter while a session is active must not take over
    green_user = 1'b1; auth_bit = 1'b1; internal_id = 3'd0;
    tick();
    green_user = 1'b0; auth_bit = 1'b0;
    tick();
    vectors++;
    if (disp_out !== 8'd16) begin
      errors++;
      $display("FAIL id_locked: disp_out=%0d expected 16", disp_out);
    end
  endtask

  task automatic test_edge_saturation();
    level_num = 4'd2; win = 1'b1;
    repeat (5) tick();
    win = 1'b0;
    tick();
    vectors++;
    if (disp_out !== 8'd18) begin
      errors++;
      $display("FAIL held_win: disp_out=%0d expected 18", disp_out);
    end
    repeat (15) win_pulse(4'd15);
    win_pulse(4'd7);
    vectors++;
    if (disp_out !== 8'd250) begin
      errors++;
      $display("FAIL reach_250: disp_out=%0d expected 250", disp_out);
    end
    win_pulse(4'd15);
    vectors++;
    if (disp_out !== 8'd255 || green_max !== 1'b1) begin
      errors++;
      $display("FAIL sat1: disp_out=%0d green_max=%0b expected 255/1", disp_out, green_max);
    end
    win_pulse(4'd15);
    vectors++;
    if (disp_out !== 8'd255) begin
      errors++;
      $display("FAIL sat2: disp_out=%0d expected 255", disp_out);
    end
  endtask

  task automatic test_ignored();
    logout();
    win_pulse(4'd9);
    win_pulse(4'd9);
    vectors++;
    if (disp_out !== 8'd0 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL idle_out: disp_out=%0d green_max=%0b expected 0/0", disp_out, green_max);
    end
    // logout outranks a same-cycle login
    log_out = 1'b1; green_user = 1'b1; auth_bit = 1'b1; internal_id = 3'd5;
    tick();
    log_out = 1'b0; green_user = 1'b0; auth_bit = 1'b0;
    tick();
    vectors++;
    if (disp_out !== 8'd0) begin
      errors++;
      $display("FAIL logout_prio: disp_out=%0d expected 0", disp_out);
    end
    login(3'd5);
    vectors++;
    if (disp_out !== S5) begin
      errors++;
      $display("FAIL idle_wins: disp_out=%0d expected %0d", disp_out, S5);
    end
    level_num = 4'd3; win = 1'b1; loose = 1'b1;
    tick();
    win = 1'b0; loose = 1'b0;
    tick();
    vectors++;
    if (disp_out !== S5) begin
      errors++;
      $display("FAIL simultaneous: disp_out=%0d expected %0d", disp_out, S5);
    end
  endtask

  task automatic test_reset_mid_session();
    rst = 1'b0; win = 1'b1; level_num = 4'd4;
    tick();
    rst = 1'b1; win = 1'b0;
    tick();
    vectors++;
    if (disp_out !== 8'd0 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: disp_out=%0d green_max=%0b expected 0/0", disp_out, green_max);
    end
    login(3'd6);
    disp_button = 1'b0;
    tick();
    vectors++;
    if (disp_out !== 8'd0 || green_max !== 1'b0) begin
      errors++;
      $display("FAIL cleared_table: disp_out=%0d green_max=%0b expected 0/0", disp_out, green_max);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_penalty();
    test_logout_highscore();
    test_edge_saturation();
    test_ignored();
    test_reset_mid_session();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
